// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S receive path (and its i2s_out counterpart).
//   DATA_SIZE_DEF : default bits per channel slot
//   BUF_WIDTH_DEF : default FIFO address width (depth = 2**BUF_WIDTH_DEF)
//   LEFT / RIGHT  : channel tag values carried alongside each word
//   state_e       : receiver framing state (SYNC until first WS edge, then RUN)
// ---------------------------------------------------------------------------
package i2s_pkg;

    localparam int DATA_SIZE_DEF = 32;
    localparam int BUF_WIDTH_DEF = 3;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/i2s_fifo.sv
// ---------------------------------------------------------------------------
// i2s_fifo
// Synchronous first-word-fall-through FIFO, depth 2**BUF_WIDTH.
//   clk, rst : system clock, synchronous active-high reset (pointers/count)
//   push     : write din this cycle (ignored when full unless a pop frees room)
//   pop      : consume the head word (ignored when empty)
//   din      : write data
//   full     : no free slot
//   empty    : no stored word
//   dout     : head word, valid whenever empty is low; forced to 0 when empty
// ---------------------------------------------------------------------------
module i2s_fifo #(
    parameter int WIDTH     = 33,
    parameter int BUF_WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int DEPTH = 1 << BUF_WIDTH;
    localparam logic [BUF_WIDTH:0] FULL_CNT = (BUF_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [BUF_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [BUF_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [BUF_WIDTH:0]   count_q, count_d;
    logic                 do_push;
    logic                 do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; empty masks whatever it holds.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/i2s_in.sv
// ---------------------------------------------------------------------------
// i2s_in
// Philips-format I2S receiver. Synchronises the external SCK/WS/SD pins into
// the system clock domain, deserialises each channel slot MSB first, and
// queues {lr, word} in a FWFT FIFO presented with the rts/rtr handshake.
//   clk, rst          : system clock, synchronous active-high reset
//   i2si_sck/ws/sd    : external serial clock, word select (0=left), data
//   i2si_rts          : head word valid (FIFO not empty)
//   i2si_data/lr      : head word and its channel tag
//   i2si_rtr          : downstream ready; word consumed on rts & rtr
//   ro_fifo_overrun   : sticky, a completed word was dropped on a full FIFO
//   ro_frame_err      : sticky, a slot ended with a bit count != DATA_SIZE
//   trig_fifo_overrun : one-cycle clear pulse for ro_fifo_overrun
//   trig_frame_err    : one-cycle clear pulse for ro_frame_err
// ---------------------------------------------------------------------------
module i2s_in
    import i2s_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int BUF_WIDTH = BUF_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i2si_sck,
    input  logic                 i2si_ws,
    input  logic                 i2si_sd,
    output logic                 i2si_rts,
    output logic [DATA_SIZE-1:0] i2si_data,
    output logic                 i2si_lr,
    input  logic                 i2si_rtr,
    output logic                 ro_fifo_overrun,
    output logic                 ro_frame_err,
    input  logic                 trig_fifo_overrun,
    input  logic                 trig_frame_err
);

    localparam int CNT_W = $clog2(2 * DATA_SIZE);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(2 * DATA_SIZE - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DATA_SIZE - 1);

    // Pin synchronisers; sck gets a third stage for edge detection.
    logic sck_s1_q, sck_s2_q, sck_s3_q;
    logic ws_s1_q, ws_s2_q;
    logic sd_s1_q, sd_s2_q;

    logic                 sck_rise;
    logic                 boundary;
    logic [DATA_SIZE-1:0] shifted;

    state_e               state_q, state_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 ws_prev_q, ws_prev_d;
    logic                 wr_en_q, wr_en_d;
    logic [DATA_SIZE:0]   wr_word_q, wr_word_d;
    logic                 fifo_overrun_q, fifo_overrun_d;
    logic                 frame_err_q, frame_err_d;
    logic                 frame_set;
    logic                 overrun_set;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_SIZE:0]   fifo_dout;

    assign sck_rise = sck_s2_q & ~sck_s3_q;
    // WS is sampled one SCK ahead of the MSB, so the bit taken on the rise
    // where WS flips is still the LSB of the slot that is ending.
    assign boundary = sck_rise & (ws_s2_q != ws_prev_q);
    assign shifted  = {shift_q[DATA_SIZE-2:0], sd_s2_q};

    // ---- stage: serial sampling and framing -------------------------------
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ws_prev_d = ws_prev_q;
        wr_en_d   = 1'b0;
        wr_word_d = wr_word_q;
        frame_set = 1'b0;

        if (sck_rise) begin
            shift_d   = shifted;
            ws_prev_d = ws_s2_q;
            if (bit_cnt_q != CNT_MAX) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
            if (boundary) begin
                bit_cnt_d = '0;
                if (state_q == SYNC) begin
                    // The slot in flight when we locked is of unknown length.
                    state_d = RUN;
                end else if (bit_cnt_q == SLOT_LAST) begin
                    wr_en_d   = 1'b1;
                    wr_word_d = {ws_prev_q, shifted};
                end else begin
                    frame_set = 1'b1;
                end
            end
        end
    end

    // A pop in the same cycle makes room, so only a stalled full FIFO drops.
    assign overrun_set = wr_en_q & fifo_full & ~i2si_rtr;

    // Set has priority over a coincident clear pulse.
    always_comb begin
        fifo_overrun_d = fifo_overrun_q;
        frame_err_d    = frame_err_q;
        if (overrun_set) begin
            fifo_overrun_d = 1'b1;
        end else if (trig_fifo_overrun) begin
            fifo_overrun_d = 1'b0;
        end
        if (frame_set) begin
            frame_err_d = 1'b1;
        end else if (trig_frame_err) begin
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s1_q       <= 1'b0;
            sck_s2_q       <= 1'b0;
            sck_s3_q       <= 1'b0;
            ws_s1_q        <= 1'b0;
            ws_s2_q        <= 1'b0;
            sd_s1_q        <= 1'b0;
            sd_s2_q        <= 1'b0;
            state_q        <= SYNC;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            ws_prev_q      <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_word_q      <= '0;
            fifo_overrun_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            sck_s1_q       <= i2si_sck;
            sck_s2_q       <= sck_s1_q;
            sck_s3_q       <= sck_s2_q;
            ws_s1_q        <= i2si_ws;
            ws_s2_q        <= ws_s1_q;
            sd_s1_q        <= i2si_sd;
            sd_s2_q        <= sd_s1_q;
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            ws_prev_q      <= ws_prev_d;
            wr_en_q        <= wr_en_d;
            wr_word_q      <= wr_word_d;
            fifo_overrun_q <= fifo_overrun_d;
            frame_err_q    <= frame_err_d;
        end
    end

    // ---- stage: FIFO write (cycle after the boundary) and FWFT read -------
    i2s_fifo #(
        .WIDTH     (DATA_SIZE + 1),
        .BUF_WIDTH (BUF_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en_q),
        .pop   (i2si_rtr),
        .din   (wr_word_q),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    assign i2si_rts        = ~fifo_empty;
    assign i2si_lr         = fifo_dout[DATA_SIZE];
    assign i2si_data       = fifo_dout[DATA_SIZE-1:0];
    assign ro_fifo_overrun = fifo_overrun_q;
    assign ro_frame_err    = frame_err_q;

endmodule
